// File: rtl/muldiv_unit.sv
// Iterative 8051 MUL AB / DIV AB unit: 8 shift cycles, then ACC and B write-back
// over the SFR byte-write port, with OV/CY flags and a done pulse.
module muldiv_unit #(
    parameter logic [7:0] SFR_ACC_ADDR = 8'hE0,
    parameter logic [7:0] SFR_B_ADDR   = 8'hF0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       op,
    input  logic [7:0] a_in,
    input  logic [7:0] b_in,
    output logic       busy,
    output logic       done,
    output logic       ov,
    output logic       cy,
    output logic [7:0] sfr_addr,
    output logic [7:0] sfr_data,
    output logic       sfr_write_en,
    output logic       sfr_write_bit_en
);

    // state | meaning
    // IDLE  | waiting for start
    // CALC  | 8 shift-add / restoring-divide iterations
    // WR_A  | ACC write-back
    // WR_B  | B write-back, done pulse, flags updated
    typedef enum logic [1:0] {IDLE, CALC, WR_A, WR_B} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        op_q, op_nxt;
    logic [7:0]  opnd, opnd_nxt;
    logic [15:0] acc, acc_nxt;
    logic        busy_nxt, done_nxt, ov_nxt, cy_nxt, we_nxt;
    logic [7:0]  addr_nxt, data_nxt;

    logic [8:0]  mul_sum;
    logic [15:0] mul_step;
    logic [8:0]  div_sh;
    logic [8:0]  div_diff;
    logic [15:0] div_step;
    logic [15:0] calc_step;

    // acc holds {P_hi, multiplier/P_lo} for MUL and {R, Q/dividend} for DIV,
    // so both ops leave the ACC result in acc[7:0] and the B result in acc[15:8].
    always_comb begin
        mul_sum   = {1'b0, acc[15:8]} + (acc[0] ? {1'b0, opnd} : 9'd0);
        mul_step  = {mul_sum, acc[7:1]};
        div_sh    = acc[15:7];
        div_diff  = div_sh - {1'b0, opnd};
        div_step  = {(div_diff[8] ? div_sh[7:0] : div_diff[7:0]), acc[6:0], ~div_diff[8]};
        calc_step = op_q ? div_step : mul_step;
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        op_nxt    = op_q;
        opnd_nxt  = opnd;
        acc_nxt   = acc;
        done_nxt  = 1'b0;
        ov_nxt    = ov;
        cy_nxt    = cy;
        we_nxt    = 1'b0;
        addr_nxt  = 8'h00;
        data_nxt  = 8'h00;
        case (state)
            IDLE: begin
                if (start) begin
                    op_nxt   = op;
                    cnt_nxt  = 4'd0;
                    ov_nxt   = 1'b0;
                    cy_nxt   = 1'b0;
                    opnd_nxt = op ? b_in : a_in;
                    acc_nxt  = {8'h00, (op ? a_in : b_in)};
                    if (op && (b_in == 8'h00)) begin
                        done_nxt = 1'b1;
                        ov_nxt   = 1'b1;
                    end else begin
                        state_nxt = CALC;
                    end
                end
            end
            CALC: begin
                acc_nxt = calc_step;
                cnt_nxt = cnt + 4'd1;
                if (cnt == 4'd7) begin
                    state_nxt = WR_A;
                    we_nxt    = 1'b1;
                    addr_nxt  = SFR_ACC_ADDR;
                    data_nxt  = calc_step[7:0];
                end
            end
            WR_A: begin
                state_nxt = WR_B;
                we_nxt    = 1'b1;
                addr_nxt  = SFR_B_ADDR;
                data_nxt  = acc[15:8];
                done_nxt  = 1'b1;
                ov_nxt    = op_q ? 1'b0 : (acc[15:8] != 8'h00);
                cy_nxt    = 1'b0;
            end
            WR_B: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            op_q         <= 1'b0;
            opnd         <= 8'h00;
            acc          <= 16'h0000;
            busy         <= 1'b0;
            done         <= 1'b0;
            ov           <= 1'b0;
            cy           <= 1'b0;
            sfr_write_en <= 1'b0;
            sfr_addr     <= 8'h00;
            sfr_data     <= 8'h00;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            op_q         <= op_nxt;
            opnd         <= opnd_nxt;
            acc          <= acc_nxt;
            busy         <= busy_nxt;
            done         <= done_nxt;
            ov           <= ov_nxt;
            cy           <= cy_nxt;
            sfr_write_en <= we_nxt;
            sfr_addr     <= addr_nxt;
            sfr_data     <= data_nxt;
        end
    end

    assign sfr_write_bit_en = 1'b0;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: MUL/DIV vectors, divide-by-zero, ignored
// restart while busy, and reset aborting an operation.
module tb_muldiv_unit;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic       op;
    logic [7:0] a_in, b_in;
    logic       busy, done, ov, cy;
    logic [7:0] sfr_addr, sfr_data;
    logic       sfr_write_en, sfr_write_bit_en;

    int n_checks = 0;
    int n_errors = 0;

    muldiv_unit #(.SFR_ACC_ADDR(8'hE0), .SFR_B_ADDR(8'hF0)) dut (
        .clock            (clock),
        .reset            (reset),
        .start            (start),
        .op               (op),
        .a_in             (a_in),
        .b_in             (b_in),
        .busy             (busy),
        .done             (done),
        .ov               (ov),
        .cy               (cy),
        .sfr_addr         (sfr_addr),
        .sfr_data         (sfr_data),
        .sfr_write_en     (sfr_write_en),
        .sfr_write_bit_en (sfr_write_bit_en)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_ov"},   ov,   0);
        check({tag, "_cy"},   cy,   0);
        check({tag, "_we"},   sfr_write_en, 0);
        check({tag, "_addr"}, sfr_addr, 0);
        check({tag, "_data"}, sfr_data, 0);
        check({tag, "_bit"},  sfr_write_bit_en, 0);
    endtask

    // Starts an op at the next edge and watches cycles 1..11 (sampled at negedge).
    // rp_cycle > 0 re-pulses start with different operands in that cycle.
    task automatic run_op(input string tag, input logic o, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] ea, input logic [7:0] eb, input logic eov,
                          input int rp_cycle);
        int dones = 0;
        int writes = 0;
        int first_done = 0;
        op = o; a_in = a; b_in = b; start = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            @(posedge clock);
            @(negedge clock);
            if (k == 1) begin
                a_in = 8'h5A; b_in = 8'hA5; op = ~o;
                check({tag, "_busy_c1"}, busy, 1);
                check({tag, "_ovclr_c1"}, ov, 0);
            end
            if (done) begin
                dones++;
                if (first_done == 0) first_done = k;
            end
            if (sfr_write_en) writes++;
            if (k == 8) begin
                check({tag, "_busy_c8"}, busy, 1);
                check({tag, "_we_c8"}, sfr_write_en, 0);
            end
            if (k == 9) begin
                check({tag, "_we_c9"}, sfr_write_en, 1);
                check({tag, "_addr_c9"}, sfr_addr, 8'hE0);
                check({tag, "_data_c9"}, sfr_data, ea);
                check({tag, "_done_c9"}, done, 0);
            end
            if (k == 10) begin
                check({tag, "_we_c10"}, sfr_write_en, 1);
                check({tag, "_addr_c10"}, sfr_addr, 8'hF0);
                check({tag, "_data_c10"}, sfr_data, eb);
                check({tag, "_done_c10"}, done, 1);
                check({tag, "_ov_c10"}, ov, eov);
                check({tag, "_cy_c10"}, cy, 0);
                check({tag, "_busy_c10"}, busy, 1);
            end
            if (k == 11) begin
                check({tag, "_busy_c11"}, busy, 0);
                check({tag, "_we_c11"}, sfr_write_en, 0);
                check({tag, "_addr_c11"}, sfr_addr, 0);
                check({tag, "_ov_hold_c11"}, ov, eov);
            end
            if (k == rp_cycle) begin
                start = 1'b1; op = 1'b0; a_in = 8'hFF; b_in = 8'hFF;
            end else begin
                start = 1'b0;
            end
        end
        check({tag, "_done_count"}, dones, 1);
        check({tag, "_done_latency"}, first_done, 10);
        check({tag, "_write_count"}, writes, 2);
    endtask

    task automatic run_div0;
        op = 1'b1; a_in = 8'h77; b_in = 8'h00; start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        check("div0_done_c1", done, 1);
        check("div0_ov_c1", ov, 1);
        check("div0_cy_c1", cy, 0);
        check("div0_busy_c1", busy, 0);
        check("div0_we_c1", sfr_write_en, 0);
        for (int k = 2; k <= 5; k++) begin
            @(posedge clock);
            @(negedge clock);
            check("div0_busy", busy, 0);
            check("div0_we", sfr_write_en, 0);
            check("div0_done_low", done, 0);
        end
    endtask

    // Starts MUL 12*34, asserts reset during cycle rst_cycle, then releases it.
    task automatic reset_mid(input string tag, input int rst_cycle);
        op = 1'b0; a_in = 8'h12; b_in = 8'h34; start = 1'b1;
        for (int k = 1; k <= rst_cycle; k++) begin
            @(posedge clock);
            @(negedge clock);
            start = 1'b0;
        end
        if (rst_cycle == 9) check({tag, "_we_before"}, sfr_write_en, 1);
        else check({tag, "_busy_before"}, busy, 1);
        reset = 1'b1;
        #1;
        check_idle_outputs({tag, "_async"});
        @(negedge clock);
        reset = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clock);
            @(negedge clock);
            check({tag, "_no_we_after"}, sfr_write_en, 0);
            check({tag, "_no_busy_after"}, busy, 0);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 1'b0; a_in = 8'h00; b_in = 8'h00;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_idle_outputs("reset");
        reset = 1'b0;
        @(negedge clock);

        run_op("mul_50_a0", 1'b0, 8'h50, 8'hA0, 8'h00, 8'h32, 1'b1, 0);
        run_op("mul_0c_0d", 1'b0, 8'h0C, 8'h0D, 8'h9C, 8'h00, 1'b0, 0);
        run_op("div_fb_12", 1'b1, 8'hFB, 8'h12, 8'h0D, 8'h11, 1'b0, 0);
        run_op("div_ff_01", 1'b1, 8'hFF, 8'h01, 8'hFF, 8'h00, 1'b0, 0);
        run_op("mul_ff_ff", 1'b0, 8'hFF, 8'hFF, 8'h01, 8'hFE, 1'b1, 0);
        run_div0();
        run_op("mul_repulse", 1'b0, 8'h12, 8'h34, 8'hA8, 8'h03, 1'b1, 4);
        run_op("mul_back2back", 1'b0, 8'h03, 8'h04, 8'h0C, 8'h00, 1'b0, 0);
        reset_mid("rst_c5", 5);
        run_op("div_after_rst", 1'b1, 8'h64, 8'h07, 8'h0E, 8'h02, 1'b0, 0);
        reset_mid("rst_wra", 9);
        run_op("div_07_64", 1'b1, 8'h07, 8'h64, 8'h00, 8'h07, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative 8051 MUL AB / DIV AB execution unit. It sits directly upstream of the accumulator and B special function registers (SFRs). On a start request it latches the A and B operands and computes the result over 8 shift cycles. It then writes the results back over the standard SFR byte-write port: ACC first, then B. It reports OV/CY flags to the PSW logic and a done pulse to the instruction sequencer.

## Interface
Parameters:
- SFR_ACC_ADDR, 8'hE0, byte address of ACC driven on sfr_addr during the A write-back
- SFR_B_ADDR, 8'hF0, byte address of B driven on sfr_addr during the B write-back

Ports:
- clock  input  1  system clock; all state changes on rising edge
- reset  input  1  asynchronous, active-high; forces IDLE and all outputs to 0
- start  input  1  begin operation; sampled only in IDLE
- op  input  1  0 = MUL AB, 1 = DIV AB; latched with start
- a_in  input  8  current ACC value; latched with start
- b_in  input  8  current B value; latched with start
- busy  output  1  high from the cycle after accepted start through the WR_B cycle
- done  output  1  one-cycle completion pulse
- ov  output  1  overflow flag; valid from done until the next accepted start
- cy  output  1  carry flag; driven 0 on every completion (8051 rule)
- sfr_addr  output  8  write-back address
- sfr_data  output  8  write-back data
- sfr_write_en  output  1  byte-write strobe toward the SFR file
- sfr_write_bit_en  output  1  tied 0; this unit never performs bit writes

## Operation
- States: IDLE, CALC, WR_A, WR_B.
- IDLE with start=1:
  - latch op, a_in, b_in;
  - clear the 4-bit iteration counter, ov and cy;
  - go to CALC.
- Exception: DIV with b_in=0 goes directly to IDLE, with done=1 and ov=1 in the next cycle, and issues no SFR writes. ACC and B are left unchanged.
- MUL (shift-add):
  - 16-bit product register P, initialised to 0.
  - Each CALC cycle: if multiplier bit[i]=1, add the multiplicand shifted by i, with i counting 0..7.
  - Equivalent LSB-first form: shift the multiplier right and add into P[15:8] with a 9-bit carry.
  - Final value: A result = P[7:0], B result = P[15:8], ov = (P[15:8] != 0).
- DIV (restoring):
  - 8-bit remainder register R and quotient register Q.
  - Each cycle: shift {R,Q} left by one, bringing in the next dividend bit MSB first.
  - Trial subtraction R-divisor, 9 bits wide. If non-negative, keep the difference and set Q bit 0; otherwise restore.
  - Final value: A result = Q, B result = R, ov = 0.
- CALC runs exactly 8 cycles; the counter goes 0..7, then WR_A.
- WR_A: sfr_write_en=1, sfr_addr=SFR_ACC_ADDR, sfr_data = A result.
- WR_B:
  - sfr_write_en=1, sfr_addr=SFR_B_ADDR, sfr_data = B result;
  - done=1 and ov/cy are updated in this cycle;
  - next state is IDLE.
- start asserted while busy is ignored; no queueing.
- Outside WR_A/WR_B: sfr_write_en=0, sfr_addr=0, sfr_data=0.

## Timing
- All outputs are registered.
- Reset values: busy=0, done=0, ov=0, cy=0, sfr_addr=0, sfr_data=0, sfr_write_en=0, sfr_write_bit_en=0, state=IDLE.
- Cycle numbering: start sampled high at edge 0.
  - Cycles 1–8: CALC, busy=1.
  - Cycle 9: WR_A.
  - Cycle 10: WR_B with done=1.
  - Cycle 11: IDLE, busy=0; the unit can accept a new start in this cycle.
- Total latency, start to done: 10 cycles. Divide-by-zero latency: 1 cycle, with busy staying 0.
- The WR_A and WR_B write strobes are on consecutive cycles. The downstream SFR captures each on the rising edge ending that cycle, so ACC is updated before B.
- Reset asserted mid-operation:
  - the operation is aborted immediately (asynchronously), with no partial writes after reset;
  - a write strobe high in the cycle reset asserts is cleared asynchronously;
  - latched operands and results are discarded.
- Operands are latched at start; changes on a_in/b_in during busy have no effect.

## Test plan
- MUL a_in=8'h50, b_in=8'hA0 -> at cycle 9 write E0←8'h00; at cycle 10 write F0←8'h32, done=1, ov=1, cy=0.
- MUL a_in=8'h0C, b_in=8'h0D -> writes E0←8'h9C, F0←8'h00; ov=0; done exactly 10 cycles after start.
- DIV a_in=8'hFB, b_in=8'h12 -> writes E0←8'h0D, F0←8'h11; ov=0, cy=0. Also DIV 8'hFF/8'h01 -> E0←8'hFF, F0←8'h00.
- DIV b_in=8'h00 -> done=1 and ov=1 in cycle 1; sfr_write_en stays 0 throughout; busy never rises.
- MUL in progress with start re-pulsed at cycle 4 using different operands -> original result written, single done pulse. Then start at cycle 11 is accepted.
- Reset asserted at cycle 5 of a MUL -> all outputs 0 immediately, no write strobes afterwards. Next start after reset release completes normally.
